// File: rtl/mult_seq_pkg.sv
// Shared types for the sequential shift-and-add multiplier.
package mult_seq_pkg;
    typedef enum logic [1:0] {IDLE, CALC, DONE} mult_seq_state_t;
endpackage

// File: rtl/adder_rc.sv
// Ripple-carry adder: s/co = a + b + ci, purely combinational.
module adder_rc #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic [WIDTH-1:0] s,
    output logic             co
);
    logic [WIDTH:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign co = c[WIDTH];
endmodule

// File: rtl/mult_seq.sv
// Sequential unsigned shift-and-add multiplier, one add+shift per clock.
// Optional ovf output enabled by defining MULT_SEQ_OVF_EN.
module mult_seq
    import mult_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p
`ifdef MULT_SEQ_OVF_EN
    ,
    output logic               ovf
`endif
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    mult_seq_state_t  state;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] sum;
    logic             carry;

    assign add_b = acc_lo[0] ? mcand : '0;

    adder_rc #(.WIDTH(WIDTH)) u_add (
        .a  (acc_hi),
        .b  (add_b),
        .ci (1'b0),
        .s  (sum),
        .co (carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mcand     <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand    <= a;
                        acc_hi   <= '0;
                        acc_lo   <= b;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    // carry becomes the new MSB; multiplier bits shift out the bottom
                    {acc_hi, acc_lo} <= {carry, sum, acc_lo[WIDTH-1:1]};
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign p = {acc_hi, acc_lo};

`ifdef MULT_SEQ_OVF_EN
    assign ovf = out_valid && (acc_hi != '0);
`endif
endmodule

// File: tb/tb_mult_seq.sv
// Self-checking bench for mult_seq: directed cases plus random operands vs a*b.
module tb_mult_seq;
    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] p;
`ifdef MULT_SEQ_OVF_EN
    logic           ovf;
`endif

    int n_vec = 0;
    int n_bad = 0;

    mult_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p)
`ifdef MULT_SEQ_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One full transaction; pulse_calc injects a stray in_valid during CALC,
    // stall holds out_ready low that many cycles in DONE.
    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y,
                         input int stall, input bit pulse_calc);
        int edges;
        int exp_p;
        exp_p = int'(x) * int'(y);
        @(negedge clk);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        a        = x;
        b        = y;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        edges    = 1;
        in_valid = 1'b0;
        a        = 'x;
        b        = 'x;
        while (!out_valid && edges < 20) begin
            if (pulse_calc && edges == 2) begin
                a        = 4'b0010;
                b        = 4'b0011;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            check("in_ready_calc", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
            edges++;
        end
        in_valid = 1'b0;
        check("latency", 32'(edges), 32'(W + 1));
        check("out_valid", 32'(out_valid), 32'd1);
        check("product", 32'(p), 32'(exp_p));
`ifdef MULT_SEQ_OVF_EN
        check("ovf", 32'(ovf), 32'((exp_p >> W) != 0));
`endif
        for (int i = 0; i < stall; i++) begin
            a        = 4'b0111;
            b        = 4'b0101;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_p", 32'(p), 32'(exp_p));
            check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("post_hs_valid", 32'(out_valid), 32'd0);
        check("post_hs_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_p", 32'(p), 32'd0);
`ifdef MULT_SEQ_OVF_EN
        check("rst_ovf", 32'(ovf), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        do_op(4'b1101, 4'b1011, 0, 1'b0);
        do_op(4'b1111, 4'b1111, 0, 1'b0);
        do_op(4'b0000, 4'b1111, 0, 1'b0);
        do_op(4'b1111, 4'b0000, 1, 1'b0);
        do_op(4'b1001, 4'b0110, 3, 1'b0);
        do_op(4'b1101, 4'b1011, 0, 1'b1);
        do_op(4'b0011, 4'b0101, 0, 1'b0);
        do_op(4'b0100, 4'b0100, 2, 1'b0);

        // reset in the middle of a calculation
        @(negedge clk);
        a        = 4'b1111;
        b        = 4'b1111;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_p", 32'(p), 32'd0);
        repeat (2) @(negedge clk);
        check("midrst_hold_p", 32'(p), 32'd0);
        rst_n = 1'b1;
        do_op(4'b0011, 4'b0101, 0, 1'b0);

        for (int k = 0; k < 40; k++) begin
            do_op(W'($urandom), W'($urandom), int'($urandom_range(0, 3)),
                  1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
